// File: rtl/rst_seq_sync.sv
// Reset sequencer: synchronizes an async reset and releases NUM_CH
// active-low channel resets one after another, STAGGER cycles apart.
// A software request re-asserts all channels for SW_PULSE cycles and
// then replays the staggered release.
module rst_seq_sync #(
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 3,
    parameter int STAGGER    = 4,
    parameter int SW_PULSE   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sw_rst_req_i,
    output logic [NUM_CH-1:0] sync_rst_o,
    output logic              rst_done_o
);

    localparam int MAX_CNT = (STAGGER > SW_PULSE) ? STAGGER : SW_PULSE;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(NUM_CH + 1);

    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(SW_PULSE - 1);
    localparam logic [IW-1:0] CH_LAST   = IW'(NUM_CH - 1);
    localparam logic [IW-1:0] CH_FIRST  = IW'(1);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2,
        ST_SWRST   = 2'd3
    } state_t;

    state_t               state_q;
    logic [NUM_STAGES-1:0] chain_q;
    logic [NUM_STAGES-1:0] chain_d;
    logic                 reqPrev_q;
    logic [CW-1:0]        stagCnt_q;
    logic [CW-1:0]        holdCnt_q;
    logic [IW-1:0]        chIdx_q;
    logic [NUM_CH-1:0]    syncRst_q;
    logic                 rstDone_q;

    logic                 chainOut;
    logic                 swReqRise;

    assign chain_d   = {chain_q[NUM_STAGES-2:0], 1'b1};
    assign chainOut  = chain_q[NUM_STAGES-1];
    assign swReqRise = sw_rst_req_i & ~reqPrev_q;

    // Shift 1s into the synchronizer once the async reset is released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    // Remember last cycle's request so a held request counts only once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reqPrev_q <= 1'b0;
        end else begin
            reqPrev_q <= sw_rst_req_i;
        end
    end

    // Sequencer FSM with registered channel resets and done flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_WAIT;
            stagCnt_q <= '0;
            holdCnt_q <= '0;
            chIdx_q   <= '0;
            syncRst_q <= '0;
            rstDone_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (chainOut) begin
                        syncRst_q[0] <= 1'b1;
                        stagCnt_q    <= '0;
                        chIdx_q      <= CH_FIRST;
                        if (NUM_CH == 1) begin
                            rstDone_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q   <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (swReqRise) begin
                        syncRst_q <= '0;
                        rstDone_q <= 1'b0;
                        holdCnt_q <= '0;
                        stagCnt_q <= '0;
                        state_q   <= ST_SWRST;
                    end else if (stagCnt_q == STAG_LAST) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (chIdx_q == IW'(k)) begin
                                syncRst_q[k] <= 1'b1;
                            end
                        end
                        stagCnt_q <= '0;
                        chIdx_q   <= chIdx_q + IW'(1);
                        if (chIdx_q == CH_LAST) begin
                            rstDone_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end else begin
                        stagCnt_q <= stagCnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (swReqRise) begin
                        syncRst_q <= '0;
                        rstDone_q <= 1'b0;
                        holdCnt_q <= '0;
                        stagCnt_q <= '0;
                        state_q   <= ST_SWRST;
                    end
                end
                ST_SWRST: begin
                    if (holdCnt_q == HOLD_LAST) begin
                        syncRst_q[0] <= 1'b1;
                        holdCnt_q    <= '0;
                        stagCnt_q    <= '0;
                        chIdx_q      <= CH_FIRST;
                        if (NUM_CH == 1) begin
                            rstDone_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q   <= ST_RELEASE;
                        end
                    end else begin
                        holdCnt_q <= holdCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign sync_rst_o = syncRst_q;
    assign rst_done_o = rstDone_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: two instances (default parameters and a
// single-channel, three-stage variant) share clock, reset and request.
// Expected outputs come from release-time arithmetic: channel k of an
// instance is released once the edge count reaches seqStart + k*STAGGER.
module tb_rst_seq_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [2:0] syncA;
    logic       doneA;
    logic [0:0] syncB;
    logic       doneB;

    int errors  = 0;
    int checks  = 0;
    int edgeNum = 0;

    bit inReset = 1'b1;
    bit reqPrev = 1'b0;
    int seqStart [2];

    rst_seq_sync dutA (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_rst_req_i (req),
        .sync_rst_o   (syncA),
        .rst_done_o   (doneA)
    );

    rst_seq_sync #(
        .NUM_STAGES (3),
        .NUM_CH     (1),
        .STAGGER    (2),
        .SW_PULSE   (3)
    ) dutB (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_rst_req_i (req),
        .sync_rst_o   (syncB),
        .rst_done_o   (doneB)
    );

    // Free-running clock, period 10 time units.
    always #5 clk = ~clk;

    function automatic int nsOf(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int ncOf(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic int stOf(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int spOf(input int i);
        return (i == 0) ? 8 : 3;
    endfunction

    function automatic logic [7:0] expSync(input int i);
        logic [7:0] v;
        v = '0;
        if (!inReset) begin
            for (int k = 0; k < ncOf(i); k++) begin
                if (edgeNum >= seqStart[i] + k * stOf(i)) v[k] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [7:0] expDone(input int i);
        logic [7:0] v;
        v = '0;
        if (!inReset && edgeNum >= seqStart[i] + (ncOf(i) - 1) * stOf(i)) v[0] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %b expected %b", tag, edgeNum, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_syncA"}, {5'b0, syncA}, expSync(0));
        checkOutput({tag, "_doneA"}, {7'b0, doneA}, expDone(0));
        checkOutput({tag, "_syncB"}, {7'b0, syncB}, expSync(1));
        checkOutput({tag, "_doneB"}, {7'b0, doneB}, expDone(1));
    endtask

    // One clock cycle: drive the request, advance the model, check outputs.
    task automatic applyStimulus(input logic reqVal);
        req = reqVal;
        @(posedge clk);
        edgeNum++;
        if (!inReset) begin
            for (int i = 0; i < 2; i++) begin
                if (reqVal && !reqPrev && (edgeNum - 1 >= seqStart[i])) begin
                    seqStart[i] = edgeNum + spOf(i);
                end
            end
            reqPrev = reqVal;
        end else begin
            reqPrev = 1'b0;
        end
        #1;
        checkAll("cycle");
    endtask

    // Assert reset mid-cycle, check the async clear, hold, release at negedge.
    task automatic hwReset(input int cycles);
        req = 1'b0;
        rst = 1'b1;
        inReset = 1'b1;
        #1;
        checkAll("asyncAssert");
        for (int c = 0; c < cycles; c++) applyStimulus(1'b0);
        @(negedge clk);
        rst = 1'b0;
        inReset = 1'b0;
        reqPrev = 1'b0;
        for (int i = 0; i < 2; i++) seqStart[i] = edgeNum + 1 + nsOf(i);
    endtask

    // Reset pulse much narrower than a clock period, placed between edges.
    task automatic glitch();
        req = 1'b0;
        #2;
        rst = 1'b1;
        inReset = 1'b1;
        #1;
        checkAll("glitch");
        rst = 1'b0;
        inReset = 1'b0;
        reqPrev = 1'b0;
        for (int i = 0; i < 2; i++) seqStart[i] = edgeNum + 1 + nsOf(i);
    endtask

    // Literal release timeline for the default instance after a reset release.
    task automatic checkReleaseTable(input string tag);
        logic [7:0] want;
        for (int r = 1; r <= 12; r++) begin
            applyStimulus(1'b0);
            want = (r < 3) ? 8'd0 : (r < 7) ? 8'd1 : (r < 11) ? 8'd3 : 8'd7;
            checkOutput({tag, "_tblA"}, {5'b0, syncA}, want);
            checkOutput({tag, "_tblDoneA"}, {7'b0, doneA}, (r >= 11) ? 8'd1 : 8'd0);
            checkOutput({tag, "_tblB"}, {7'b0, syncB}, (r >= 4) ? 8'd1 : 8'd0);
            checkOutput({tag, "_tblDoneB"}, {7'b0, doneB}, (r >= 4) ? 8'd1 : 8'd0);
        end
    endtask

    // Literal timeline for a software request issued from DONE.
    task automatic checkSwTable(input string tag, input bit extraReq);
        logic [7:0] want;
        applyStimulus(1'b1);
        checkOutput({tag, "_swA0"}, {5'b0, syncA}, 8'd0);
        checkOutput({tag, "_swDoneA0"}, {7'b0, doneA}, 8'd0);
        for (int j = 1; j <= 17; j++) begin
            applyStimulus(extraReq && (j == 3));
            want = (j < 8) ? 8'd0 : (j < 12) ? 8'd1 : (j < 16) ? 8'd3 : 8'd7;
            checkOutput({tag, "_swA"}, {5'b0, syncA}, want);
            checkOutput({tag, "_swDoneA"}, {7'b0, doneA}, (j >= 16) ? 8'd1 : 8'd0);
        end
    endtask

    // Main stimulus: directed scenarios followed by randomized traffic.
    initial begin
        seqStart[0] = 32'h3fff_ffff;
        seqStart[1] = 32'h3fff_ffff;
        #1;
        hwReset(5);
        checkReleaseTable("power");

        checkSwTable("swDone", 1'b0);

        hwReset(2);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0);
        hwReset(3);
        checkReleaseTable("midRelease");

        hwReset(3);
        applyStimulus(1'b1);
        for (int c = 0; c < 12; c++) applyStimulus(1'b0);
        checkSwTable("ignoredReq", 1'b1);

        for (int c = 0; c < 3; c++) applyStimulus(1'b0);
        glitch();
        checkReleaseTable("glitch");

        for (int c = 0; c < 1500; c++) begin
            int r;
            int h;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                hwReset($urandom_range(1, 4));
            end else if (r < 4) begin
                glitch();
            end else if (r < 12) begin
                h = $urandom_range(1, 4);
                for (int j = 0; j < h; j++) applyStimulus(1'b1);
            end else begin
                applyStimulus(1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time so a stuck bench still reports.
    initial begin
        #1000000;
        errors++;
        checks++;
        $display("[TB] FAIL watchdog: run exceeded time limit at edge %0d", edgeNum);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
